// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared encodings for the ALU command sequencer:
//   - command opcodes as seen on cmd_op (OP_RST .. OP_CMP)
//   - ALU select-line encodings (ALU_SEL_*) and load/shift sub-selects (ALU_LS_*)
//   - sequencer FSM state encoding (ST_IDLE / ST_EXEC / ST_RESP)
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    // Command opcodes; the 3-bit field is fully decoded, 111 is compare.
    localparam logic [2:0] OP_RST = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    // ALU main select; SUB and CMP share the subtractor.
    localparam logic [1:0] ALU_SEL_LS  = 2'b00;
    localparam logic [1:0] ALU_SEL_NOR = 2'b01;
    localparam logic [1:0] ALU_SEL_ADD = 2'b10;
    localparam logic [1:0] ALU_SEL_SUB = 2'b11;

    // Load/shift sub-select, only meaningful when the main select is ALU_SEL_LS.
    localparam logic [1:0] ALU_LS_RST = 2'b00;
    localparam logic [1:0] ALU_LS_SHL = 2'b01;
    localparam logic [1:0] ALU_LS_LD  = 2'b10;
    localparam logic [1:0] ALU_LS_SHR = 2'b11;

    // Sequencer states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Purely combinational opcode decoder for the ALU sequencer.
// Ports:
//   i_op            command opcode (OP_RST .. OP_CMP)
//   o_alu_sel       ALU main select lines
//   o_alu_ls        ALU load/shift sub-select
//   o_wr_acc        1 when the ALU result is written back to the accumulator
//   o_is_shift      1 for SHL/SHR, which may repeat for several cycles
//   o_a_from_data   1 when ALU operand a comes from the command data (LD)
// ---------------------------------------------------------------------------
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] i_op,
    output logic [1:0] o_alu_sel,
    output logic [1:0] o_alu_ls,
    output logic       o_wr_acc,
    output logic       o_is_shift,
    output logic       o_a_from_data
);

    // Map each opcode onto the ALU select lines and the sequencer control
    // bits. CMP drives the subtractor exactly like SUB but leaves the
    // accumulator untouched, so only its write-enable differs.
    always_comb begin
        o_alu_sel     = ALU_SEL_LS;
        o_alu_ls      = ALU_LS_RST;
        o_wr_acc      = 1'b1;
        o_is_shift    = 1'b0;
        o_a_from_data = 1'b0;
        case (i_op)
            OP_RST: begin
                o_alu_sel = ALU_SEL_LS;
                o_alu_ls  = ALU_LS_RST;
            end
            OP_LD: begin
                o_alu_sel     = ALU_SEL_LS;
                o_alu_ls      = ALU_LS_LD;
                o_a_from_data = 1'b1;
            end
            OP_SHL: begin
                o_alu_sel  = ALU_SEL_LS;
                o_alu_ls   = ALU_LS_SHL;
                o_is_shift = 1'b1;
            end
            OP_SHR: begin
                o_alu_sel  = ALU_SEL_LS;
                o_alu_ls   = ALU_LS_SHR;
                o_is_shift = 1'b1;
            end
            OP_NOR: o_alu_sel = ALU_SEL_NOR;
            OP_ADD: o_alu_sel = ALU_SEL_ADD;
            OP_SUB: o_alu_sel = ALU_SEL_SUB;
            OP_CMP: begin
                o_alu_sel = ALU_SEL_SUB;
                o_wr_acc  = 1'b0;
            end
            default: begin
                o_alu_sel = ALU_SEL_LS;
                o_alu_ls  = ALU_LS_RST;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Command-driven controller for an external 8-bit combinational ALU. Owns the
// accumulator and the carry/zero flag registers, accepts one command at a time
// over a valid/ready port, repeats shift ops for multi-bit shifts and returns
// a response over a second valid/ready port.
// Ports:
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_op, cmd_data, cmd_cnt   opcode, operand, shift repeat count minus one
//   alu_a, alu_b                ALU operands (zero outside EXEC)
//   alu_sel, alu_ls             ALU select lines (RST encoding outside EXEC)
//   alu_result/cout/zout        ALU outputs
//   acc_out, flag_c, flag_z     architectural accumulator and flags
//   rsp_valid/rsp_ready         response handshake
//   busy                        high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    output logic [1:0]       alu_ls,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_zout,
    output logic [WIDTH-1:0] acc_out,
    output logic             flag_c,
    output logic             flag_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             busy
);

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_iter;
    logic [WIDTH-1:0] r_acc;
    logic             r_flag_c;
    logic             r_flag_z;

    logic [1:0]       w_dec_sel;
    logic [1:0]       w_dec_ls;
    logic             w_wr_acc;
    logic             w_is_shift;
    logic             w_a_from_data;
    logic             w_exec;
    logic             w_last_iter;

    // Decode always runs from the latched opcode, so the ALU controls stay
    // stable for the whole command regardless of what cmd_op does meanwhile.
    alu_op_decode u_decode (
        .i_op          (r_op),
        .o_alu_sel     (w_dec_sel),
        .o_alu_ls      (w_dec_ls),
        .o_wr_acc      (w_wr_acc),
        .o_is_shift    (w_is_shift),
        .o_a_from_data (w_a_from_data)
    );

    assign w_exec      = (r_state == ST_EXEC);
    assign w_last_iter = !w_is_shift || (r_iter == r_cnt);

    // The ALU is parked in its RST encoding with zero operands whenever no
    // command is executing, so it never toggles while the sequencer is idle.
    assign alu_sel = w_exec ? w_dec_sel : ALU_SEL_LS;
    assign alu_ls  = w_exec ? w_dec_ls  : ALU_LS_RST;
    assign alu_a   = w_exec ? (w_a_from_data ? r_data : r_acc) : '0;
    assign alu_b   = w_exec ? r_data : '0;

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign acc_out   = r_acc;
    assign flag_c    = r_flag_c;
    assign flag_z    = r_flag_z;

    // Control FSM: latch the command in IDLE, stay in EXEC until the last
    // shift iteration (a single cycle for everything else), then hold the
    // response until it is consumed. Reset drops any in-flight command, so an
    // aborted shift never produces a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_iter  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_data  <= cmd_data;
                        r_cnt   <= cmd_cnt;
                        r_iter  <= '0;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_last_iter) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_iter <= r_iter + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Architectural state: flags follow the ALU on every EXEC cycle, so for a
    // repeated SHL the carry left behind is the bit pushed out by the final
    // iteration. Compare updates the flags but never the accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b1;
        end else if (w_exec) begin
            r_flag_c <= alu_cout;
            r_flag_z <= alu_zout;
            if (w_wr_acc) begin
                r_acc <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer with a behavioural 8-bit ALU attached
// to the select/operand lines. Commands come from a vector table; each expected
// result is queued when the command is issued and checked when the response
// appears. Hand-written sequences cover response back-pressure, commands
// offered while busy, and reset in the middle of a multi-cycle shift.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic [2:0] cnt;
        logic [7:0] acc;
        logic       c;
        logic       z;
        int         lat;
    } vecRecT;

    logic       clk;
    logic       rstN;
    logic       cmdValid;
    logic       cmdReady;
    logic [2:0] cmdOp;
    logic [7:0] cmdData;
    logic [2:0] cmdCnt;
    logic [7:0] aluA;
    logic [7:0] aluB;
    logic [1:0] aluSel;
    logic [1:0] aluLs;
    logic [7:0] aluResult;
    logic       aluCout;
    logic       aluZout;
    logic [7:0] accOut;
    logic       flagC;
    logic       flagZ;
    logic       rspValid;
    logic       rspReady;
    logic       busy;

    int     nVectors    = 0;
    int     nMiscompares = 0;
    vecRecT vectors[17];
    vecRecT sbQueue[$];

    alu_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .cmd_valid  (cmdValid),
        .cmd_ready  (cmdReady),
        .cmd_op     (cmdOp),
        .cmd_data   (cmdData),
        .cmd_cnt    (cmdCnt),
        .alu_a      (aluA),
        .alu_b      (aluB),
        .alu_sel    (aluSel),
        .alu_ls     (aluLs),
        .alu_result (aluResult),
        .alu_cout   (aluCout),
        .alu_zout   (aluZout),
        .acc_out    (accOut),
        .flag_c     (flagC),
        .flag_z     (flagZ),
        .rsp_valid  (rspValid),
        .rsp_ready  (rspReady),
        .busy       (busy)
    );

    // 100 MHz clock; the DUT acts on rising edges, the bench on falling ones.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: bit 8 of the 9-bit result is the carry/borrow, so a
    // subtract borrows exactly when a < b and a left shift pushes out a[7].
    logic [8:0] aluFull;
    always_comb begin
        aluFull = 9'd0;
        case (aluSel)
            2'b10: aluFull = {1'b0, aluA} + {1'b0, aluB};
            2'b11: aluFull = {1'b0, aluA} - {1'b0, aluB};
            2'b01: aluFull = {1'b0, ~(aluA | aluB)};
            default: begin
                case (aluLs)
                    2'b11:   aluFull = {1'b0, aluA >> 1};
                    2'b01:   aluFull = {aluA, 1'b0};
                    2'b10:   aluFull = {1'b0, aluA};
                    default: aluFull = 9'd0;
                endcase
            end
        endcase
    end
    assign aluResult = aluFull[7:0];
    assign aluCout   = aluFull[8];
    assign aluZout   = (aluFull[7:0] == 8'd0);

    // Hard stop in case something upstream of the bounded waits hangs.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison; every call counts, every mismatch prints a FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        nVectors++;
        if (actual !== required) begin
            nMiscompares++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, required);
        end
    endtask

    task automatic reportTimeout(input string name);
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic pushExpected(input vecRecT v);
        sbQueue.push_back(v);
    endtask

    // Offer a command at a falling edge once cmd_ready is seen; returns at
    // the falling edge right after the accepting rising edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data,
                                 input logic [2:0] cnt);
        int waitCycles = 0;
        while (!cmdReady && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!cmdReady) begin
            reportTimeout("cmd_ready_wait");
            return;
        end
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdData  = data;
        cmdCnt   = cnt;
        @(negedge clk);
        cmdValid = 1'b0;
    endtask

    // Count EXEC cycles until rsp_valid, then pop and compare the scoreboard.
    task automatic awaitResponse(input string name);
        vecRecT exp;
        int     cycles = 0;
        while (!rspValid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (!rspValid) begin
            reportTimeout({name, "_rsp"});
            return;
        end
        if (sbQueue.size() == 0) begin
            reportTimeout({name, "_sb_empty"});
            return;
        end
        exp = sbQueue.pop_front();
        checkOutput({name, "_acc"}, 32'(accOut), 32'(exp.acc));
        checkOutput({name, "_c"},   32'(flagC),  32'(exp.c));
        checkOutput({name, "_z"},   32'(flagZ),  32'(exp.z));
        if (exp.lat > 0) begin
            checkOutput({name, "_lat"}, 32'(cycles), 32'(exp.lat));
        end
    endtask

    task automatic releaseResponse(input string name);
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        checkOutput({name, "_idle"}, 32'(cmdReady), 32'd1);
    endtask

    // Main sequence: reset, vector table, then the multi-cycle corner cases.
    initial begin
        int     sawRsp;
        vecRecT v;

        vectors[0]  = '{OP_LD,  8'h3C, 3'd0, 8'h3C, 1'b0, 1'b0, 1};
        vectors[1]  = '{OP_RST, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1, 1};
        vectors[2]  = '{OP_LD,  8'hF0, 3'd0, 8'hF0, 1'b0, 1'b0, 1};
        vectors[3]  = '{OP_ADD, 8'h20, 3'd0, 8'h10, 1'b1, 1'b0, 1};
        vectors[4]  = '{OP_SUB, 8'h10, 3'd0, 8'h00, 1'b0, 1'b1, 1};
        vectors[5]  = '{OP_LD,  8'h05, 3'd0, 8'h05, 1'b0, 1'b0, 1};
        vectors[6]  = '{OP_CMP, 8'h07, 3'd0, 8'h05, 1'b1, 1'b0, 1};
        vectors[7]  = '{OP_LD,  8'h81, 3'd0, 8'h81, 1'b0, 1'b0, 1};
        vectors[8]  = '{OP_SHL, 8'h00, 3'd2, 8'h08, 1'b0, 1'b0, 3};
        vectors[9]  = '{OP_LD,  8'h81, 3'd0, 8'h81, 1'b0, 1'b0, 1};
        vectors[10] = '{OP_SHR, 8'h00, 3'd7, 8'h00, 1'b0, 1'b1, 8};
        vectors[11] = '{OP_NOR, 8'h0F, 3'd0, 8'hF0, 1'b0, 1'b0, 1};
        vectors[12] = '{OP_ADD, 8'h10, 3'd5, 8'h00, 1'b1, 1'b1, 1};
        vectors[13] = '{OP_SHL, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1, 1};
        vectors[14] = '{OP_LD,  8'h80, 3'd0, 8'h80, 1'b0, 1'b0, 1};
        vectors[15] = '{OP_SHL, 8'h00, 3'd0, 8'h00, 1'b1, 1'b1, 1};
        vectors[16] = '{OP_SUB, 8'h01, 3'd0, 8'hFF, 1'b1, 1'b0, 1};

        rstN     = 1'b0;
        cmdValid = 1'b0;
        cmdOp    = 3'd0;
        cmdData  = 8'd0;
        cmdCnt   = 3'd0;
        rspReady = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        checkOutput("rst_acc",       32'(accOut),   32'h00);
        checkOutput("rst_c",         32'(flagC),    32'd0);
        checkOutput("rst_z",         32'(flagZ),    32'd1);
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd1);
        checkOutput("rst_busy",      32'(busy),     32'd0);
        checkOutput("rst_alu_sel",   32'({aluSel, aluLs}), 32'd0);
        checkOutput("rst_alu_ab",    32'({aluA, aluB}),    32'd0);

        for (int i = 0; i < 17; i++) begin
            v = vectors[i];
            pushExpected(v);
            applyStimulus(v.op, v.data, v.cnt);
            awaitResponse($sformatf("vec%0d", i));
            releaseResponse($sformatf("vec%0d", i));
        end

        // Back-pressure: response held for 5 cycles while another command is
        // offered; neither the response nor the accumulator may move.
        pushExpected('{OP_LD, 8'h5A, 3'd0, 8'h5A, 1'b0, 1'b0, 1});
        applyStimulus(OP_LD, 8'h5A, 3'd0);
        awaitResponse("hold_ld");
        cmdValid = 1'b1;
        cmdOp    = OP_LD;
        cmdData  = 8'h11;
        cmdCnt   = 3'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("hold%0d_rsp_valid", k), 32'(rspValid), 32'd1);
            checkOutput($sformatf("hold%0d_cmd_ready", k), 32'(cmdReady), 32'd0);
            checkOutput($sformatf("hold%0d_acc", k),       32'(accOut),   32'h5A);
        end
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        checkOutput("busy_cmd_not_taken", 32'(accOut),   32'h5A);
        checkOutput("busy_back_idle",     32'(cmdReady), 32'd1);
        pushExpected('{OP_LD, 8'h11, 3'd0, 8'h11, 1'b0, 1'b0, 1});
        @(negedge clk);
        cmdValid = 1'b0;
        awaitResponse("late_ld");
        releaseResponse("late_ld");

        // Reset in the middle of an 8-step shift: aborts with no response.
        pushExpected('{OP_LD, 8'h81, 3'd0, 8'h81, 1'b0, 1'b0, 1});
        applyStimulus(OP_LD, 8'h81, 3'd0);
        awaitResponse("pre_abort_ld");
        releaseResponse("pre_abort_ld");
        applyStimulus(OP_SHL, 8'h00, 3'd7);
        repeat (2) @(negedge clk);
        checkOutput("abort_mid_busy", 32'(busy), 32'd1);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("abort_cmd_ready", 32'(cmdReady), 32'd1);
        checkOutput("abort_busy",      32'(busy),     32'd0);
        checkOutput("abort_acc",       32'(accOut),   32'h00);
        checkOutput("abort_c",         32'(flagC),    32'd0);
        checkOutput("abort_z",         32'(flagZ),    32'd1);
        checkOutput("abort_rsp_valid", 32'(rspValid), 32'd0);
        sawRsp = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (rspValid) sawRsp = 1;
        end
        checkOutput("abort_no_stale_rsp", 32'(sawRsp), 32'd0);
        checkOutput("abort_acc_after",    32'(accOut), 32'h00);

        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
